// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the NOP encoding used for IF/ID bubbles, and the PC increment helper.
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,  // post-reset, no request yet
        REQ  = 2'd1,  // request outstanding at pc
        HOLD = 2'd2,  // fetched word parked in the hold buffer (stall)
        DROP = 2'd3   // request for a squashed path still in flight
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    // Modulo-2^32 increment; the low two bits are carried through unchanged.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_holdbuf.sv
// ----------------------------------------------------------------------------
// fetch_holdbuf
// One-entry instruction buffer. Captures a fetched word when the pipeline
// cannot accept it, so the stall does not cost a re-fetch.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   load_i   capture data_i (wins over clr_i)
//   clr_i    drop the held word
//   data_i   word to capture
//   data_o   held word (NOP when empty)
//   valid_o  buffer holds a word
// ----------------------------------------------------------------------------
module fetch_holdbuf
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        clr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        valid_o
);

    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (clr_i) begin
            data_d  = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch and IF/ID pipeline register of the 5-stage MIPS pipeline.
// Owns the PC, talks to instruction memory over a req/ack handshake and
// delivers instructions into IF/ID without loss or duplication under
// load-use stalls, branch/jump redirects and variable memory latency.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pc_write, if_id_write  hazard-unit enables; both must be 1 to advance
//   redirect_valid/_pc     taken branch/jump; flushes IF and IF/ID
//   imem_req/_addr         fetch request, held stable until acked
//   imem_ack/_rdata        memory response, data valid in the ack cycle only
//   if_id_valid            IF/ID holds a real instruction (0 = bubble)
//   if_id_instr            IF/ID instruction (NOP when invalid)
//   if_id_pc_plus4         PC+4 of the IF/ID instruction
// ----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;

    logic         hb_load, hb_clr, hb_valid;
    logic [31:0]  hb_data;
    logic         adv;

    // A disagreement between the two hazard enables is treated as a stall.
    assign adv = pc_write & if_id_write;

    fetch_holdbuf u_holdbuf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (hb_load),
        .clr_i   (hb_clr),
        .data_i  (imem_rdata),
        .data_o  (hb_data),
        .valid_o (hb_valid)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        hb_load      = 1'b0;
        hb_clr       = 1'b0;

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end

            REQ: begin
                if (redirect_valid) begin
                    // Redirect beats stall: flush IF/ID, squash this fetch.
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    if (imem_ack) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Request must stay stable until acked, so park the
                        // target and drain the in-flight fetch first.
                        pend_pc_d = redirect_pc;
                        state_d   = DROP;
                    end
                end else if (imem_ack) begin
                    if (adv) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = pc_next(pc_q);
                        pc_d         = pc_next(pc_q);
                    end else begin
                        hb_load = 1'b1;
                        state_d = HOLD;
                    end
                end else if (adv) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                    hb_clr       = 1'b1;
                    pc_d         = redirect_pc;
                    state_d      = REQ;
                end else if (adv) begin
                    ifid_valid_d = hb_valid;
                    ifid_instr_d = hb_data;
                    ifid_pc4_d   = pc_next(pc_q);
                    pc_d         = pc_next(pc_q);
                    hb_clr       = 1'b1;
                    state_d      = REQ;
                end
            end

            DROP: begin
                // Nothing real can enter IF/ID while draining the dead fetch.
                if (redirect_valid || adv) begin
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = NOP_INSTR;
                end
                if (imem_ack) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            pend_pc_q    <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // Decoded from registered state only; no path from imem_ack.
    assign imem_req       = (state_q == REQ) || (state_q == DROP);
    assign imem_addr      = pc_q;
    assign if_id_valid    = ifid_valid_q;
    assign if_id_instr    = ifid_instr_q;
    assign if_id_pc_plus4 = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. A second instance with RESET_PC at the top
// of the address space shares the stimulus to exercise PC wrap-around.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, if_id_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc_plus4;
    logic        d2_req, d2_valid;
    logic [31:0] d2_addr, d2_instr, d2_pc4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .if_id_write(if_id_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_id_valid(d2_valid),
        .if_id_instr(d2_instr), .if_id_pc_plus4(d2_pc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] instr,
                              input logic [31:0] pc4);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, v});
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc4"},   if_id_pc_plus4, pc4);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of memory response; rdata is a simple function of the address.
    task automatic mem_cycle(input logic ack, input logic adv);
        imem_ack       = ack;
        imem_rdata     = imem_addr ^ K;
        pc_write       = adv;
        if_id_write    = adv;
        redirect_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        step();  // BOOT -> REQ
    endtask

    initial begin
        // ---------------- reset values ----------------
        rst_n = 1'b0; pc_write = 1'b0; if_id_write = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        step();
        step();
        chk("rst.req",   {31'h0, imem_req}, 32'h0);
        chk("rst.addr",  imem_addr, 32'h0);
        check_ifid("rst", 1'b0, 32'h0, 32'h0);
        chk("rst.wrap_addr", d2_addr, 32'hFFFF_FFFC);

        // ---------------- 1: zero-wait stream + wrap ----------------
        do_reset();
        chk("t1.first_req", {31'h0, imem_req}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("t1.addr", imem_addr, 32'(4 * i));
            mem_cycle(1'b1, 1'b1);
            check_ifid("t1", 1'b1, 32'(4 * i) ^ K, 32'(4 * i + 4));
            if (i == 0) begin
                chk("t6.wrap_addr", d2_addr, 32'h0);
                chk("t6.wrap_pc4",  d2_pc4, 32'h0);
            end
        end

        // ---------------- 2: load-use stall ----------------
        do_reset();
        mem_cycle(1'b1, 1'b1);
        mem_cycle(1'b1, 1'b1);
        chk("t2.addr8", imem_addr, 32'h8);
        mem_cycle(1'b1, 1'b0);                 // ack with stall -> HOLD
        chk("t2.hold_req", {31'h0, imem_req}, 32'h0);
        check_ifid("t2.hold", 1'b1, 32'h4 ^ K, 32'h8);
        imem_ack = 1'b0; pc_write = 1'b1; if_id_write = 1'b0;  // mismatch = stall
        step();
        chk("t2.hold2_req", {31'h0, imem_req}, 32'h0);
        check_ifid("t2.hold2", 1'b1, 32'h4 ^ K, 32'h8);
        mem_cycle(1'b0, 1'b1);                 // release: buffer issues
        check_ifid("t2.issue", 1'b1, 32'h8 ^ K, 32'hC);
        chk("t2.next_req",  {31'h0, imem_req}, 32'h1);
        chk("t2.next_addr", imem_addr, 32'hC);
        mem_cycle(1'b1, 1'b1);
        check_ifid("t2.after", 1'b1, 32'hC ^ K, 32'h10);

        // ---------------- 3: wait states ----------------
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 3; w++) begin
                mem_cycle(1'b0, 1'b1);
                chk("t3.bub_valid", {31'h0, if_id_valid}, 32'h0);
                chk("t3.bub_instr", if_id_instr, 32'h0);
                chk("t3.wait_addr", imem_addr, 32'(4 * r));
                chk("t3.wait_req",  {31'h0, imem_req}, 32'h1);
            end
            mem_cycle(1'b1, 1'b1);
            check_ifid("t3.ack", 1'b1, 32'(4 * r) ^ K, 32'(4 * r + 4));
        end

        // ---------------- 4: redirect while waiting ----------------
        do_reset();
        for (int i = 0; i < 4; i++) mem_cycle(1'b1, 1'b1);
        chk("t4.addr10", imem_addr, 32'h10);
        imem_ack = 1'b0; pc_write = 1'b1; if_id_write = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();                                // -> DROP
        chk("t4.drop_req",  {31'h0, imem_req}, 32'h1);
        chk("t4.drop_addr", imem_addr, 32'h10);
        check_ifid("t4.flush", 1'b0, 32'h0, 32'h10);
        mem_cycle(1'b0, 1'b1);
        chk("t4.drop_addr2", imem_addr, 32'h10);
        mem_cycle(1'b1, 1'b1);                 // dead data acked
        chk("t4.new_addr", imem_addr, 32'h100);
        chk("t4.no_leak",  {31'h0, if_id_valid}, 32'h0);
        mem_cycle(1'b1, 1'b1);
        check_ifid("t4.target", 1'b1, 32'h100 ^ K, 32'h104);
        // latest redirect wins while draining
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h180;
        step();
        redirect_pc = 32'h1C0;
        step();
        mem_cycle(1'b1, 1'b1);
        chk("t4.latest", imem_addr, 32'h1C0);
        // redirect coinciding with the draining ack
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h240;
        step();
        imem_ack = 1'b1; redirect_pc = 32'h280;
        step();
        chk("t4.same_cycle", imem_addr, 32'h280);

        // ---------------- 5: redirect during stall ----------------
        do_reset();
        mem_cycle(1'b1, 1'b1);
        mem_cycle(1'b1, 1'b0);                 // -> HOLD with addr 4 buffered
        chk("t5.hold_req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b0; pc_write = 1'b0; if_id_write = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        chk("t5.flush_valid", {31'h0, if_id_valid}, 32'h0);
        chk("t5.flush_instr", if_id_instr, 32'h0);
        chk("t5.req",  {31'h0, imem_req}, 32'h1);
        chk("t5.addr", imem_addr, 32'h200);
        mem_cycle(1'b1, 1'b1);
        check_ifid("t5.target", 1'b1, 32'h200 ^ K, 32'h204);

        // ---------------- 6: reset during DROP ----------------
        do_reset();
        mem_cycle(1'b1, 1'b1);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();                                // -> DROP
        chk("t6.in_drop", {31'h0, imem_req}, 32'h1);
        chk("t6.pre_pc4", if_id_pc_plus4, 32'h4);
        imem_ack = 1'b1; redirect_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("t6.async_req",  {31'h0, imem_req}, 32'h0);
        chk("t6.async_addr", imem_addr, 32'h0);
        check_ifid("t6.async", 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();                                // BOOT edge with ack still high
        chk("t6.post_addr",  imem_addr, 32'h0);
        chk("t6.post_valid", {31'h0, if_id_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
